// File: rtl/latq_bank_wr_ctrl.sv
// Write sequencer for a bank of positive-level latch words: turns a valid/ready
// request into a registered one-hot enable pulse framed by data setup and hold cycles.
module latq_bank_wr_ctrl #(
  parameter int WORDS     = 8,
  parameter int WIDTH     = 8,
  parameter int AW        = 3,
  parameter int EN_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic [WORDS-1:0] LAT_E,
  output logic [WIDTH-1:0] LAT_D,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int             AWP      = AW + 1;
  localparam logic [AW:0]    WORDS_C  = AWP'(WORDS);
  localparam logic [3:0]     CNT_LOAD = 4'(EN_CYCLES - 1);
  localparam logic [WORDS-1:0] ONE_C  = {{(WORDS-1){1'b0}}, 1'b1};

  state_t           state_r, state_n;
  logic [AW-1:0]    addr_r, addr_n;
  logic [3:0]       cnt_r, cnt_n;
  logic [WORDS-1:0] lat_e_r, lat_e_n;
  logic [WIDTH-1:0] lat_d_r, lat_d_n;
  logic             err_r, err_n;
  logic             ready_r, busy_r;
  logic             in_range_s;

  assign in_range_s = ({1'b0, addr_r} < WORDS_C);

  // Next-state and next-output decode; enables and data are only ever changed here.
  always_comb begin
    state_n = state_r;
    addr_n  = addr_r;
    cnt_n   = cnt_r;
    lat_e_n = lat_e_r;
    lat_d_n = lat_d_r;
    err_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (WR_VALID) begin
          addr_n  = WR_ADDR;
          lat_d_n = WR_DATA;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      SETUP: begin
        if (in_range_s) begin
          lat_e_n = ONE_C << addr_r;
          cnt_n   = CNT_LOAD;
          state_n = PULSE;
        end else begin
          lat_e_n = '0;
          err_n   = 1'b1;
          state_n = HOLD;
        end
      end
      PULSE: begin
        if (cnt_r == 4'd0) begin
          lat_e_n = '0;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      HOLD: begin
        lat_e_n = '0;
        state_n = IDLE;
      end
      default: begin
        lat_e_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, even mid-pulse.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_r <= IDLE;
      addr_r  <= '0;
      cnt_r   <= 4'd0;
      lat_e_r <= '0;
      lat_d_r <= '0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      addr_r  <= addr_n;
      cnt_r   <= cnt_n;
      lat_e_r <= lat_e_n;
      lat_d_r <= lat_d_n;
      err_r   <= err_n;
      ready_r <= (state_n == IDLE);
      busy_r  <= (state_n != IDLE);
    end
  end

  assign WR_READY = ready_r;
  assign BUSY     = busy_r;
  assign LAT_E    = lat_e_r;
  assign LAT_D    = lat_d_r;
  assign ERR      = err_r;

endmodule

// File: doc/latq_bank_wr_ctrl.md
Name: latq_bank_wr_ctrl

Overview:
- Synchronous write sequencer that sits directly upstream of a bank of positive-level latq latch cells, one latch word per address.
- Converts a valid/ready write request into a glitch-free, one-hot latch-enable pulse (LAT_E) and a stable data bus (LAT_D).
- Guarantees one cycle of data setup before the enable pulse and one cycle of data hold after it.
- Lets latch-based storage be written safely from flop-based logic.

Parameters:
- WORDS, 8, number of latch words (one LAT_E bit each); range 2..64.
- WIDTH, 8, data width of each latch word.
- AW, 3, write-address width; WORDS <= 2**AW.
- EN_CYCLES, 1, width of the LAT_E pulse in clock cycles; range 1..15.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, synchronous, active-low; sampled on the rising edge of CLK.
- WR_VALID  input  1  write request valid.
- WR_READY  output  1  controller can accept a request.
- WR_ADDR  input  AW  target latch word.
- WR_DATA  input  WIDTH  data to write.
- LAT_E  output  WORDS  one-hot latch enables, registered.
- LAT_D  output  WIDTH  data to all latch D inputs, registered.
- BUSY  output  1  high in any state other than IDLE.
- ERR  output  1  one-cycle pulse: an out-of-range address was accepted.

Behaviour:
- All outputs are driven directly from flops. No combinational path from any input to LAT_E. WR_READY is decoded from the state register only.
- Reset, RN=0 at an edge:
  - State goes to IDLE.
  - LAT_E=0, LAT_D=0, BUSY=0, ERR=0, WR_READY=1 from the following cycle.
  - Pulse counter is cleared.
- Reset has priority over every other event, including mid-pulse: LAT_E drops to 0 at that same edge.
- States: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - WR_READY=1.
  - Handshake: WR_VALID=1 at an edge is accepted. WR_ADDR is captured into addr_q and WR_DATA into LAT_D, then go to SETUP.
  - WR_VALID=0: stay in IDLE. LAT_D keeps its last value.
- SETUP (1 cycle):
  - WR_READY=0, LAT_E=0, LAT_D stable.
  - If addr_q < WORDS: next edge sets LAT_E[addr_q]=1, loads the counter with EN_CYCLES-1, and goes to PULSE.
  - If addr_q >= WORDS: next edge pulses ERR=1 for one cycle, keeps LAT_E=0, and goes to HOLD.
- PULSE (EN_CYCLES cycles):
  - Exactly one LAT_E bit is high and LAT_D is stable.
  - The counter decrements each edge.
  - At the edge where the counter equals 0: LAT_E is cleared to 0 and the state goes to HOLD.
- HOLD (1 cycle): LAT_E=0, LAT_D unchanged. Next edge goes to IDLE.
- Latency and throughput:
  - Request accepted at edge e0.
  - LAT_D valid after e0.
  - LAT_E high from e1 to e(1+EN_CYCLES).
  - WR_READY high again after e(2+EN_CYCLES).
  - Back-to-back period is 3+EN_CYCLES cycles.
- WR_ADDR and WR_DATA are ignored while WR_READY=0. Inputs that change during SETUP, PULSE or HOLD have no effect.
- LAT_D changes only at an accepting edge or at reset. It never changes while any LAT_E bit is high, or in the cycle before or after.
- At most one LAT_E bit is high at any time. LAT_E is never high outside PULSE.
- BUSY = (state != IDLE).
- ERR is high only in the single cycle after an out-of-range SETUP.

Test Plan:
- Reset: hold RN=0 for 2 cycles with WR_VALID=1 -> LAT_E=0, LAT_D=0, BUSY=0, ERR=0, no accept. After release, WR_READY=1.
- Single write: defaults, ADDR=5, DATA=0xA5, accepted at e0 -> LAT_D=0xA5 after e0. LAT_E=0x20 for exactly 1 cycle, from e1 to e2. WR_READY returns after e3.
- Wide pulse, EN_CYCLES=3, ADDR=0, DATA=0x3C -> LAT_E=0x01 for 3 cycles. LAT_D=0x3C is stable from 1 cycle before through 1 cycle after the pulse. Period is 6 cycles.
- Back-to-back: WR_VALID held high with writes (1,0x11), (7,0xEE) -> second accept 4 cycles after the first. LAT_E goes 0x02 then 0x80, never overlapping. WR_DATA changes mid-sequence are ignored.
- Out of range: WORDS=6, ADDR=6 -> ERR=1 for one cycle, LAT_E stays 0, controller returns to IDLE normally.
- Reset mid-pulse: EN_CYCLES=4, assert RN=0 during the 2nd PULSE cycle -> LAT_E=0 and LAT_D=0 at that edge, state IDLE. A subsequent write works normally.
